// File: rtl/rv32i_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_exec_ctrl
// Description : RV32I execute/control slice. It decodes the instruction,
//               muxes ALU operands, runs the ALU and branch comparator, and
//               drives the PC-select, writeback and store controls.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_exec_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    output logic [31:0] o_alu_data,
    output logic [31:0] o_pc_br,
    output logic        o_pc_sel,
    output logic [1:0]  o_wb_sel,
    output logic        o_rd_wren,
    output logic        o_mem_wren,
    output logic        o_br_less,
    output logic        o_br_equal,
    output logic        o_insn_vld,
    output logic        o_insn_vld_q
);

    localparam logic [3:0] c_ALU_ADD    = 4'd0;
    localparam logic [3:0] c_ALU_SUB    = 4'd1;
    localparam logic [3:0] c_ALU_SLL    = 4'd2;
    localparam logic [3:0] c_ALU_SLT    = 4'd3;
    localparam logic [3:0] c_ALU_SLTU   = 4'd4;
    localparam logic [3:0] c_ALU_XOR    = 4'd5;
    localparam logic [3:0] c_ALU_SRL    = 4'd6;
    localparam logic [3:0] c_ALU_SRA    = 4'd7;
    localparam logic [3:0] c_ALU_OR     = 4'd8;
    localparam logic [3:0] c_ALU_AND    = 4'd9;
    localparam logic [3:0] c_ALU_PASS_B = 4'd10;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] c_WB_PC4  = 2'd0;
    localparam logic [1:0] c_WB_ALU  = 2'd1;
    localparam logic [1:0] c_WB_LOAD = 2'd2;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_unused;

    logic        w_opa_sel;
    logic        w_opb_sel;
    logic [3:0]  w_alu_op;
    logic [1:0]  w_wb_sel;
    logic        w_rd_wren;
    logic        w_mem_wren;
    logic        w_pc_sel;
    logic        w_vld;
    logic        w_is_jalr;
    logic        w_br_uns;
    logic        w_br_less;
    logic        w_br_equal;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;

    logic        r_insn_vld_q;

    assign w_opcode = i_instruction[6:0];
    assign w_funct3 = i_instruction[14:12];
    assign w_funct7 = i_instruction[31:25];
    // Register indices are resolved by the regfile, not here.
    assign w_unused = ^{i_instruction[24:15], i_instruction[11:7]};

    // funct3 -> ALU op, shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    // Comparator always looks at the raw register operands.
    assign w_br_uns   = (w_opcode == c_OPC_BRANCH) && (w_funct3[2:1] == 2'b11);
    assign w_br_equal = (i_rs1_data == i_rs2_data);
    assign w_br_less  = w_br_uns ? (i_rs1_data < i_rs2_data)
                                 : ($signed(i_rs1_data) < $signed(i_rs2_data));

    always_comb begin
        w_opa_sel  = 1'b0;
        w_opb_sel  = 1'b0;
        w_alu_op   = c_ALU_ADD;
        w_wb_sel   = c_WB_ALU;
        w_rd_wren  = 1'b0;
        w_mem_wren = 1'b0;
        w_pc_sel   = 1'b0;
        w_vld      = 1'b0;
        w_is_jalr  = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                if ((w_funct7 == 7'h00) ||
                    ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))) begin
                    w_vld     = 1'b1;
                    w_alu_op  = f_alu_op(w_funct3, w_funct7[5]);
                    w_rd_wren = 1'b1;
                end
            end
            c_OPC_OPIMM: begin
                if (((w_funct3 != 3'b001) && (w_funct3 != 3'b101)) ||
                    ((w_funct3 == 3'b001) && (w_funct7 == 7'h00)) ||
                    ((w_funct3 == 3'b101) && ((w_funct7 == 7'h00) || (w_funct7 == 7'h20)))) begin
                    w_vld     = 1'b1;
                    w_opb_sel = 1'b1;
                    w_alu_op  = f_alu_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                    w_rd_wren = 1'b1;
                end
            end
            c_OPC_LOAD: begin
                w_vld     = 1'b1;
                w_opb_sel = 1'b1;
                w_wb_sel  = c_WB_LOAD;
                w_rd_wren = 1'b1;
            end
            c_OPC_STORE: begin
                w_vld      = 1'b1;
                w_opb_sel  = 1'b1;
                w_mem_wren = 1'b1;
            end
            c_OPC_BRANCH: begin
                if (w_funct3[2:1] != 2'b01) begin
                    w_vld     = 1'b1;
                    w_opa_sel = 1'b1;
                    w_opb_sel = 1'b1;
                    case (w_funct3)
                        3'b000:  w_pc_sel = w_br_equal;
                        3'b001:  w_pc_sel = ~w_br_equal;
                        3'b100,
                        3'b110:  w_pc_sel = w_br_less;
                        default: w_pc_sel = ~w_br_less;
                    endcase
                end
            end
            c_OPC_JAL: begin
                w_vld     = 1'b1;
                w_opa_sel = 1'b1;
                w_opb_sel = 1'b1;
                w_wb_sel  = c_WB_PC4;
                w_rd_wren = 1'b1;
                w_pc_sel  = 1'b1;
            end
            c_OPC_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_vld     = 1'b1;
                    w_is_jalr = 1'b1;
                    w_opb_sel = 1'b1;
                    w_wb_sel  = c_WB_PC4;
                    w_rd_wren = 1'b1;
                    w_pc_sel  = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_vld     = 1'b1;
                w_opb_sel = 1'b1;
                w_alu_op  = c_ALU_PASS_B;
                w_rd_wren = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_vld     = 1'b1;
                w_opa_sel = 1'b1;
                w_opb_sel = 1'b1;
                w_rd_wren = 1'b1;
            end
            default: begin
                w_vld = 1'b0;
            end
        endcase
    end

    assign w_op_a  = w_opa_sel ? i_pc  : i_rs1_data;
    assign w_op_b  = w_opb_sel ? i_imm : i_rs2_data;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = 32'd0;
        case (w_alu_op)
            c_ALU_ADD:    w_alu = w_op_a + w_op_b;
            c_ALU_SUB:    w_alu = w_op_a - w_op_b;
            c_ALU_SLL:    w_alu = w_op_a << w_shamt;
            c_ALU_SLT:    w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            c_ALU_SLTU:   w_alu = {31'd0, w_op_a < w_op_b};
            c_ALU_XOR:    w_alu = w_op_a ^ w_op_b;
            c_ALU_SRL:    w_alu = w_op_a >> w_shamt;
            c_ALU_SRA:    w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            c_ALU_OR:     w_alu = w_op_a | w_op_b;
            c_ALU_AND:    w_alu = w_op_a & w_op_b;
            c_ALU_PASS_B: w_alu = w_op_b;
            default:      w_alu = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_insn_vld_q <= 1'b0;
        end else begin
            r_insn_vld_q <= w_vld;
        end
    end

    assign o_alu_data   = w_alu;
    assign o_pc_br      = {w_alu[31:1], w_alu[0] & ~w_is_jalr};
    // Side-effecting enables are held off while reset is asserted.
    assign o_pc_sel     = w_pc_sel   & ~i_rst;
    assign o_rd_wren    = w_rd_wren  & ~i_rst;
    assign o_mem_wren   = w_mem_wren & ~i_rst;
    assign o_wb_sel     = w_wb_sel;
    assign o_br_less    = w_br_less;
    assign o_br_equal   = w_br_equal;
    assign o_insn_vld   = w_vld;
    assign o_insn_vld_q = r_insn_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_exec_ctrl
// Description : Directed and randomized checks of rv32i_exec_ctrl against a
//               per-instruction-class reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_exec_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] r_ins, r_pc, r_rs1, r_rs2, r_imm;
    logic [31:0] w_alu, w_pc_br;
    logic        w_pc_sel, w_rd_wren, w_mem_wren, w_less, w_eq, w_vld, w_vld_q;
    logic [1:0]  w_wb_sel;

    int n_vec = 0;
    int n_err = 0;

    // Expected values from the model
    logic [31:0] e_alu, e_pcbr;
    logic [1:0]  e_wb;
    logic        e_pcsel, e_rd, e_mw, e_less, e_eq, e_vld;

    rv32i_exec_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instruction (r_ins),
        .i_pc          (r_pc),
        .i_rs1_data    (r_rs1),
        .i_rs2_data    (r_rs2),
        .i_imm         (r_imm),
        .o_alu_data    (w_alu),
        .o_pc_br       (w_pc_br),
        .o_pc_sel      (w_pc_sel),
        .o_wb_sel      (w_wb_sel),
        .o_rd_wren     (w_rd_wren),
        .o_mem_wren    (w_mem_wren),
        .o_br_less     (w_less),
        .o_br_equal    (w_eq),
        .o_insn_vld    (w_vld),
        .o_insn_vld_q  (w_vld_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result of an ALU-style instruction computed straight from the mnemonic meaning.
    function automatic logic [31:0] calc(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model();
        logic [2:0] f3;
        logic [6:0] f7;
        logic       lt_s, lt_u;
        f3 = r_ins[14:12];
        f7 = r_ins[31:25];
        lt_s = $signed(r_rs1) < $signed(r_rs2);
        lt_u = r_rs1 < r_rs2;
        e_vld = 0; e_alu = 0; e_wb = 2'd1; e_rd = 0; e_mw = 0; e_pcsel = 0;
        e_eq   = (r_rs1 == r_rs2);
        e_less = (r_ins[6:0] == 7'b1100011 && (f3 == 3'd6 || f3 == 3'd7)) ? lt_u : lt_s;
        case (r_ins[6:0])
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                e_vld = 1; e_rd = 1; e_alu = calc(f3, f7 == 7'h20, r_rs1, r_rs2);
            end
            7'b0010011: if ((f3 != 1 && f3 != 5) || (f3 == 1 && f7 == 0) ||
                            (f3 == 5 && (f7 == 0 || f7 == 7'h20))) begin
                e_vld = 1; e_rd = 1; e_alu = calc(f3, f3 == 5 && f7 == 7'h20, r_rs1, r_imm);
            end
            7'b0000011: begin e_vld = 1; e_rd = 1; e_wb = 2'd2; e_alu = r_rs1 + r_imm; end
            7'b0100011: begin e_vld = 1; e_mw = 1; e_alu = r_rs1 + r_imm; end
            7'b1100011: if (f3 != 2 && f3 != 3) begin
                e_vld = 1; e_alu = r_pc + r_imm;
                case (f3)
                    3'd0: e_pcsel = e_eq;
                    3'd1: e_pcsel = !e_eq;
                    3'd4: e_pcsel = lt_s;
                    3'd5: e_pcsel = !lt_s;
                    3'd6: e_pcsel = lt_u;
                    default: e_pcsel = !lt_u;
                endcase
            end
            7'b1101111: begin e_vld = 1; e_rd = 1; e_wb = 0; e_pcsel = 1; e_alu = r_pc + r_imm; end
            7'b1100111: if (f3 == 0) begin
                e_vld = 1; e_rd = 1; e_wb = 0; e_pcsel = 1; e_alu = r_rs1 + r_imm;
            end
            7'b0110111: begin e_vld = 1; e_rd = 1; e_alu = r_imm; end
            7'b0010111: begin e_vld = 1; e_rd = 1; e_alu = r_pc + r_imm; end
            default: e_vld = 0;
        endcase
        e_pcbr = (r_ins[6:0] == 7'b1100111) ? (e_alu & ~32'd1) : e_alu;
    endtask

    // Drive one vector, check combinational outputs, then the registered flag after the edge.
    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic rs);
        r_ins = ins; r_pc = pc; r_rs1 = a; r_rs2 = b; r_imm = imm; rst = rs;
        model();
        @(negedge clk);
        check("insn_vld", {31'd0, w_vld}, {31'd0, e_vld});
        check("rd_wren", {31'd0, w_rd_wren}, {31'd0, e_rd & !rs});
        check("mem_wren", {31'd0, w_mem_wren}, {31'd0, e_mw & !rs});
        check("pc_sel", {31'd0, w_pc_sel}, {31'd0, e_pcsel & !rs});
        check("br_less", {31'd0, w_less}, {31'd0, e_less});
        check("br_equal", {31'd0, w_eq}, {31'd0, e_eq});
        if (e_vld) check("alu_data", w_alu, e_alu);
        if (e_vld && e_pcsel) check("pc_br", w_pc_br, e_pcbr);
        if (!e_vld || e_rd) check("wb_sel", {30'd0, w_wb_sel}, {30'd0, e_wb});
        @(posedge clk);
        #1;
        check("insn_vld_q", {31'd0, w_vld_q}, {31'd0, e_vld & !rs});
    endtask

    initial begin
        logic [6:0]  opc_tab [10];
        logic [31:0] ins, a, b;
        logic [6:0]  f7;
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        r_ins = 0; r_pc = 0; r_rs1 = 0; r_rs2 = 0; r_imm = 0; rst = 1;
        @(posedge clk);
        #1;
        check("reset_vld_q", {31'd0, w_vld_q}, 32'd0);
        rst = 0;

        apply(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd0, 1'b0);
        check("add_alu", w_alu, 32'd12);
        apply(32'h402081B3, 32'h0, 32'd5, 32'd7, 32'd0, 1'b0);
        check("sub_alu", w_alu, 32'hFFFFFFFE);
        apply(32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8, 1'b0);
        check("blt_pc_br", w_pc_br, 32'h108);
        check("blt_pc_sel", {31'd0, w_pc_sel}, 32'd1);
        apply(32'h0020E463, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8, 1'b0);
        check("bltu_less", {31'd0, w_less}, 32'd0);
        apply(32'h4040D193, 32'h0, 32'h80000000, 32'd0, 32'h404, 1'b0);
        check("srai_alu", w_alu, 32'hF8000000);
        apply(32'h0020A023, 32'h0, 32'h1000, 32'd3, 32'd0, 1'b0);
        check("sw_mem_wren", {31'd0, w_mem_wren}, 32'd1);
        apply(32'h0020A023, 32'h0, 32'h1000, 32'd3, 32'd0, 1'b1);
        apply(32'h00000000, 32'h0, 32'd9, 32'd9, 32'd0, 1'b0);
        apply(32'h000080E7, 32'h40, 32'h203, 32'd0, 32'h10, 1'b0);   // JALR with odd target
        apply(32'h002081B3, 32'h0, 32'd1, 32'd2, 32'd0, 1'b1);      // valid insn under reset

        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            ins[6:0] = opc_tab[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h00;
                default: f7 = 7'($urandom);
            endcase
            ins[31:25] = f7;
            if (ins[6:0] == 7'b1100111 && $urandom_range(0, 3) != 0) ins[14:12] = 3'd0;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom_range(0, 40);
                2: b = ~a;
                default: b = $urandom;
            endcase
            apply(ins, $urandom, a, b, $urandom, ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
